// File: rtl/legv8_pkg.sv
// Shared definitions for the multicycle LEGv8 control path: opcodes, states, ALU codes.
package legv8_pkg;

    // Full 11-bit opcodes (instruction bits [31:21])
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    // CBZ only fixes the upper 8 bits; the low 3 belong to the branch offset
    localparam logic [7:0]  OpCbzHi = 8'b10110100;

    // ALU function select
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluPassB  = 2'b01;
    localparam logic [1:0] AluDecode = 2'b10;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExR    = 4'd2,
        StExAddr = 4'd3,
        StExCbz  = 4'd4,
        StMemRd  = 4'd5,
        StMemWr  = 4'd6,
        StWbR    = 4'd7,
        StWbLd   = 4'd8,
        StErr    = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        ClsR       = 3'd0,
        ClsLd      = 3'd1,
        ClsSt      = 3'd2,
        ClsCbz     = 3'd3,
        ClsIllegal = 3'd4
    } instr_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps the 11-bit opcode to an instruction class.
module ctrl_decode
    import legv8_pkg::*;
(
    input  logic [10:0]  opcode_i,
    output instr_class_e class_o
);

    // Exact-match decode; CBZ matches on its upper 8 bits only
    always_comb begin
        class_o = ClsIllegal;
        if (opcode_i == OpLdur) begin
            class_o = ClsLd;
        end else if (opcode_i == OpStur) begin
            class_o = ClsSt;
        end else if (opcode_i == OpAdd || opcode_i == OpSub ||
                     opcode_i == OpAnd || opcode_i == OpOrr) begin
            class_o = ClsR;
        end else if (opcode_i[10:3] == OpCbzHi) begin
            class_o = ClsCbz;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM with bounded data-memory wait and retired-instruction count.
module multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic [3:0]  state_o,
    output logic [31:0] instr_count,
    output logic        error
);

    localparam int unsigned     WaitW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d, wait_inc;
    logic [31:0]      count_q;
    logic             error_q;
    logic             retire;
    instr_class_e     cls;

    ctrl_decode u_decode (
        .opcode_i (opcode),
        .class_o  (cls)
    );

    assign wait_inc = wait_q + 1'b1;

    // Next-state, wait counter and retire decode
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        retire  = 1'b0;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (cls)
                    ClsR:        state_d = StExR;
                    ClsLd, ClsSt: state_d = StExAddr;
                    ClsCbz:      state_d = StExCbz;
                    default:     state_d = StErr;
                endcase
            end
            StExR:    state_d = StWbR;
            StWbR: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StExAddr: begin
                // Opcode must stay a memory op; anything else is treated as illegal
                if (cls == ClsLd) begin
                    state_d = StMemRd;
                end else if (cls == ClsSt) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StErr;
                end
            end
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StWbLd;
                end else if (wait_inc == WaitMax) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (wait_inc == WaitMax) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StWbLd: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StExCbz: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StErr:    state_d = StErr;
            default:  state_d = StErr;
        endcase
    end

    // State, wait counter, retire count and sticky error; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
            wait_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
            if (state_d == StErr) begin
                error_q <= 1'b1;
            end
        end
    end

    // Moore control decode from current state; only CBZ's pc_write/pc_src follow zero
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = AluAdd;
        if (reset) begin
            unique case (state_q)
                StFetch: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                StDecode: reg2loc = (cls == ClsSt) || (cls == ClsCbz);
                StExR:    alu_op  = AluDecode;
                StWbR:    reg_write = 1'b1;
                StExAddr: begin
                    alu_src = 1'b1;
                    reg2loc = (cls == ClsSt);
                end
                StMemRd:  mem_read = 1'b1;
                StMemWr: begin
                    mem_write = 1'b1;
                    reg2loc   = 1'b1;
                end
                StWbLd: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StExCbz: begin
                    alu_op   = AluPassB;
                    reg2loc  = 1'b1;
                    pc_write = zero;
                    pc_src   = zero;
                end
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign instr_count = count_q;
    assign error       = error_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: per-cycle state, control outputs and retire count.
module tb_multicycle_ctrl;

    localparam logic [3:0] SF = 4'd0, SD = 4'd1, SXR = 4'd2, SXA = 4'd3, SXC = 4'd4;
    localparam logic [3:0] SMR = 4'd5, SMW = 4'd6, SWR = 4'd7, SWL = 4'd8, SE = 4'd9;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] LD   = 11'b11111000010;
    localparam logic [10:0] ST   = 11'b11111000000;
    localparam logic [10:0] CBZA = 11'b10110100101;
    localparam logic [10:0] CBZB = 11'b10110100010;
    localparam logic [10:0] ILL  = 11'b00000000000;

    // outs = {pc_write, pc_src, ir_write, reg2loc, alu_src, mem_read, mem_write,
    //         mem_to_reg, reg_write, alu_op[1:0], error}
    localparam logic [11:0] O_NONE = 12'h000, O_FETCH = 12'hA00, O_DEC_B = 12'h100;
    localparam logic [11:0] O_EXR = 12'h004, O_WBR = 12'h008, O_EXA_L = 12'h080;
    localparam logic [11:0] O_EXA_S = 12'h180, O_MRD = 12'h040, O_MWR = 12'h120;
    localparam logic [11:0] O_WBL = 12'h018, O_CBZ_T = 12'hD02, O_CBZ_N = 12'h102;
    localparam logic [11:0] O_ERR = 12'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero, mem_ready;
    logic        pc_write, pc_src, ir_write, reg2loc, alu_src;
    logic        mem_read, mem_write, mem_to_reg, reg_write, error;
    logic [1:0]  alu_op;
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    logic [11:0] outs_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .reg2loc     (reg2loc),
        .alu_src     (alu_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .state_o     (state_o),
        .instr_count (instr_count),
        .error       (error)
    );

    assign outs_w = {pc_write, pc_src, ir_write, reg2loc, alu_src, mem_read, mem_write,
                     mem_to_reg, reg_write, alu_op, error};

    typedef struct packed {
        logic        rst_n;
        logic [10:0] op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [11:0] outs;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [10:0] op, input logic z,
                                input logic rdy, input logic [3:0] st,
                                input logic [11:0] outs, input logic [31:0] cnt);
        vec_t v;
        v.rst_n = r; v.op = op; v.z = z; v.rdy = rdy;
        v.st = st; v.outs = outs; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, compare 1 ns later, then let one rising edge pass
    task automatic apply(input vec_t v, input string tag);
        reset = v.rst_n; opcode = v.op; zero = v.z; mem_ready = v.rdy;
        #1;
        check($sformatf("%s state", tag), 32'(state_o), 32'(v.st));
        check($sformatf("%s outs", tag), 32'(outs_w), 32'(v.outs));
        check($sformatf("%s count", tag), instr_count, v.cnt);
        check($sformatf("%s rd_wr_excl", tag), 32'(mem_read & mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b0; opcode = ADD; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);

        // Reset state, then ADD, LDUR (ready on 3rd wait), STUR (ready at once), CBZ x2
        vecs.push_back(mk(0, ADD,  0, 0, SF,  O_NONE,  0));
        vecs.push_back(mk(1, ADD,  0, 1, SF,  O_FETCH, 0));
        vecs.push_back(mk(1, ADD,  0, 1, SD,  O_NONE,  0));
        vecs.push_back(mk(1, ADD,  0, 1, SXR, O_EXR,   0));
        vecs.push_back(mk(1, ADD,  0, 1, SWR, O_WBR,   0));
        vecs.push_back(mk(1, LD,   0, 0, SF,  O_FETCH, 1));
        vecs.push_back(mk(1, LD,   0, 0, SD,  O_NONE,  1));
        vecs.push_back(mk(1, LD,   0, 0, SXA, O_EXA_L, 1));
        vecs.push_back(mk(1, LD,   0, 0, SMR, O_MRD,   1));
        vecs.push_back(mk(1, LD,   0, 0, SMR, O_MRD,   1));
        vecs.push_back(mk(1, LD,   0, 1, SMR, O_MRD,   1));
        vecs.push_back(mk(1, LD,   0, 0, SWL, O_WBL,   1));
        vecs.push_back(mk(1, ST,   0, 1, SF,  O_FETCH, 2));
        vecs.push_back(mk(1, ST,   0, 1, SD,  O_DEC_B, 2));
        vecs.push_back(mk(1, ST,   0, 1, SXA, O_EXA_S, 2));
        vecs.push_back(mk(1, ST,   0, 1, SMW, O_MWR,   2));
        vecs.push_back(mk(1, CBZA, 1, 0, SF,  O_FETCH, 3));
        vecs.push_back(mk(1, CBZA, 1, 0, SD,  O_DEC_B, 3));
        vecs.push_back(mk(1, CBZA, 1, 0, SXC, O_CBZ_T, 3));
        vecs.push_back(mk(1, CBZB, 0, 0, SF,  O_FETCH, 4));
        vecs.push_back(mk(1, CBZB, 0, 0, SD,  O_DEC_B, 4));
        vecs.push_back(mk(1, CBZB, 0, 0, SXC, O_CBZ_N, 4));
        vecs.push_back(mk(1, ADD,  0, 0, SF,  O_FETCH, 5));
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Illegal opcode: sticky ERR, then reset clears count and error
        reset_pulse();
        apply(mk(0, ILL, 0, 0, SF, O_NONE,  0), "rst_cnt");
        apply(mk(1, ILL, 0, 0, SF, O_FETCH, 0), "ill_f");
        apply(mk(1, ILL, 0, 0, SD, O_NONE,  0), "ill_d");
        apply(mk(1, ILL, 0, 0, SE, O_ERR,   0), "ill_e0");
        apply(mk(1, ADD, 0, 0, SE, O_ERR,   0), "ill_e1");
        apply(mk(1, ADD, 1, 1, SE, O_ERR,   0), "ill_e2");
        reset_pulse();
        apply(mk(0, LD, 0, 0, SF, O_NONE, 0), "ill_rst");

        // LDUR timeout: exactly 15 cycles in MEM_RD, then ERR
        apply(mk(1, LD, 0, 0, SF,  O_FETCH, 0), "tmo_f");
        apply(mk(1, LD, 0, 0, SD,  O_NONE,  0), "tmo_d");
        apply(mk(1, LD, 0, 0, SXA, O_EXA_L, 0), "tmo_a");
        for (int k = 0; k < 15; k++) apply(mk(1, LD, 0, 0, SMR, O_MRD, 0), $sformatf("tmo_w%0d", k));
        apply(mk(1, LD, 0, 0, SE, O_ERR, 0), "tmo_e0");
        apply(mk(1, LD, 0, 1, SE, O_ERR, 0), "tmo_e1");

        // Reset mid-wait abandons the load; then a one-cycle MEM_RD load retires
        reset_pulse();
        apply(mk(0, LD, 0, 0, SF, O_NONE, 0), "mid_rst0");
        apply(mk(1, LD, 0, 0, SF,  O_FETCH, 0), "mid_f");
        apply(mk(1, LD, 0, 0, SD,  O_NONE,  0), "mid_d");
        apply(mk(1, LD, 0, 0, SXA, O_EXA_L, 0), "mid_a");
        for (int k = 0; k < 5; k++) apply(mk(1, LD, 0, 0, SMR, O_MRD, 0), $sformatf("mid_w%0d", k));
        reset_pulse();
        apply(mk(0, LD, 0, 0, SF, O_NONE, 0), "mid_rst1");
        apply(mk(1, LD, 0, 0, SF,  O_FETCH, 0), "fast_f");
        apply(mk(1, LD, 0, 0, SD,  O_NONE,  0), "fast_d");
        apply(mk(1, LD, 0, 0, SXA, O_EXA_L, 0), "fast_a");
        apply(mk(1, LD, 0, 1, SMR, O_MRD,   0), "fast_m");
        apply(mk(1, LD, 0, 0, SWL, O_WBL,   0), "fast_wb");
        apply(mk(1, LD, 0, 0, SF,  O_FETCH, 1), "fast_ret");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
